// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: arbitrates the shared byte-addressed, big-endian data memory
// between the CPU memory stage (port A) and a loader/debug master (port B).
// Each accepted request becomes exactly one memory cycle (IDLE -> ACCESS -> RESP).
// Requests with an illegal size or an out-of-range address are rejected
// (IDLE -> RESP) and never reach the memory.
// Optional build macro DMEM_ALIGN_CHECK_EN: when it is defined, a half at an odd
// address or a word that is not 4-byte aligned is also rejected. When it is not
// defined, unaligned accesses go to the memory byte by byte, big-endian.
module dmem_access_ctrl #(
   parameter int ADDR_W    = 11,
   parameter int MEM_BYTES = 2048,
   parameter bit FAIR      = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   // port A
   input  logic              a_req,
   input  logic              a_we,
   input  logic [1:0]        a_size,
   input  logic              a_signed,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [31:0]       a_wdata,
   output logic              a_ack,
   output logic [31:0]       a_rdata,
   output logic              a_err,
   // port B
   input  logic              b_req,
   input  logic              b_we,
   input  logic [1:0]        b_size,
   input  logic              b_signed,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [31:0]       b_wdata,
   output logic              b_ack,
   output logic [31:0]       b_rdata,
   output logic              b_err,
   // data memory
   output logic              dm_cs,
   output logic              dm_r,
   output logic              dm_w,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wdata,
   output logic [1:0]        dm_bit_s,
   input  logic [31:0]       dm_rdata,
   output logic              busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic GNT_A = 1'b0;
   localparam logic GNT_B = 1'b1;

   // Highest legal byte address, one bit wider than the address so that the
   // last byte touched by an access can be compared without wrapping.
   localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);
   localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

   logic [1:0]        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              gnt_q, gnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              pick_b;
   logic              sel_we;
   logic [1:0]        sel_size;
   logic              sel_signed;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [ADDR_W:0]   span;
   logic [ADDR_W:0]   last_addr;
   logic              misalign;
   logic              sel_err;
   logic [31:0]       load_data;
   logic              in_access;
   logic              in_resp;

   // Arbitration: round-robin on a tie when FAIR, otherwise port A always wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      pick_b = 1'b0;
      if (FAIR) begin
         if (a_req && b_req) pick_b = (last_grant_q == GNT_A);
         else                pick_b = b_req;
      end else begin
         pick_b = !a_req;
      end
   end

   // Winner's request fields.
   always_comb begin
      sel_we     = pick_b ? b_we     : a_we;
      sel_size   = pick_b ? b_size   : a_size;
      sel_signed = pick_b ? b_signed : a_signed;
      sel_addr   = pick_b ? b_addr   : a_addr;
      sel_wdata  = pick_b ? b_wdata  : a_wdata;
   end

   // Size, range and (optionally) alignment checks on the winning request.
   always_comb begin
      span = '0;
      case (sel_size)
         2'd0:    span = ONE;
         2'd1:    span = (ADDR_W+1)'(2);
         2'd2:    span = (ADDR_W+1)'(4);
         default: span = '0;
      endcase
      last_addr = {1'b0, sel_addr} + span - ONE;
`ifdef DMEM_ALIGN_CHECK_EN
      misalign = ((sel_size == 2'd1) && sel_addr[0]) ||
                 ((sel_size == 2'd2) && (sel_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      sel_err = (sel_size == 2'd3) || (last_addr > LAST_BYTE) || misalign;
   end

   // Big-endian load extraction: the addressed byte/half sits at the top of dm_rdata.
   always_comb begin
      load_data = dm_rdata;
      case (size_q)
         2'd0:    load_data = {{24{signed_q & dm_rdata[31]}}, dm_rdata[31:24]};
         2'd1:    load_data = {{16{signed_q & dm_rdata[31]}}, dm_rdata[31:16]};
         default: load_data = dm_rdata;
      endcase
   end

   // Next-state and request-capture logic.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      we_d         = we_q;
      size_d       = size_q;
      signed_d     = signed_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      err_d        = err_q;
      rdata_d      = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (a_req || b_req) begin
               gnt_d        = pick_b;
               last_grant_d = pick_b;
               we_d         = sel_we;
               size_d       = sel_size;
               signed_d     = sel_signed;
               addr_d       = sel_addr;
               wdata_d      = sel_wdata;
               err_d        = sel_err;
               rdata_d      = '0;
               state_d      = sel_err ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            rdata_d = we_q ? 32'd0 : load_data;
            state_d = S_RESP;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the datapath registers are reset too; they are few, and resetting them keeps every output at zero out of reset.
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= GNT_B;
         gnt_q        <= GNT_A;
         we_q         <= 1'b0;
         size_q       <= 2'd0;
         signed_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         we_q         <= we_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
      end
   end

   // Memory strobes decode straight from state, so an async reset removes them at once.
   always_comb begin
      in_access = (state_q == S_ACCESS);
      in_resp   = (state_q == S_RESP);
      dm_cs     = in_access;
      dm_r      = in_access & ~we_q;
      dm_w      = in_access & we_q;
      dm_addr   = in_access ? addr_q  : '0;
      dm_wdata  = in_access ? wdata_q : '0;
      dm_bit_s  = in_access ? size_q  : 2'd0;
      busy      = (state_q != S_IDLE);
   end

   // Response outputs: only the granted port sees ack/rdata/err, only in RESP.
   always_comb begin
      a_ack   = in_resp & (gnt_q == GNT_A);
      b_ack   = in_resp & (gnt_q == GNT_B);
      a_rdata = a_ack ? rdata_q : 32'd0;
      b_rdata = b_ack ? rdata_q : 32'd0;
      a_err   = a_ack & err_q;
      b_err   = b_ack & err_q;
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed, table-driven bench for dmem_access_ctrl with a
// behavioural big-endian 2 KB memory (writes on the falling clock edge).
module tb_dmem_access_ctrl;

   localparam int ADDR_W = 11;
   localparam bit FAIR   = 1'b1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              a_req, a_we, a_signed;
   logic [1:0]        a_size;
   logic [ADDR_W-1:0] a_addr;
   logic [31:0]       a_wdata;
   logic              a_ack, a_err;
   logic [31:0]       a_rdata;
   logic              b_req, b_we, b_signed;
   logic [1:0]        b_size;
   logic [ADDR_W-1:0] b_addr;
   logic [31:0]       b_wdata;
   logic              b_ack, b_err;
   logic [31:0]       b_rdata;
   logic              dm_cs, dm_r, dm_w;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata;
   logic [1:0]        dm_bit_s;
   logic [31:0]       dm_rdata;
   logic              busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:2047];

   always #5 clk = ~clk;

   dmem_access_ctrl #(.ADDR_W(ADDR_W), .MEM_BYTES(2048), .FAIR(FAIR)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_signed(a_signed),
      .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_signed(b_signed),
      .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
      .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_bit_s(dm_bit_s), .dm_rdata(dm_rdata), .busy(busy)
   );

   // Combinational big-endian read of four consecutive bytes.
   assign dm_rdata = {mem[dm_addr], mem[dm_addr + 11'd1], mem[dm_addr + 11'd2], mem[dm_addr + 11'd3]};

   // Stores land on the falling edge.
   always @(negedge clk) begin
      if (dm_cs && dm_w) begin
         case (dm_bit_s)
            2'd0: mem[dm_addr] <= dm_wdata[7:0];
            2'd1: begin
               mem[dm_addr]         <= dm_wdata[15:8];
               mem[dm_addr + 11'd1] <= dm_wdata[7:0];
            end
            default: begin
               mem[dm_addr]         <= dm_wdata[31:24];
               mem[dm_addr + 11'd1] <= dm_wdata[23:16];
               mem[dm_addr + 11'd2] <= dm_wdata[15:8];
               mem[dm_addr + 11'd3] <= dm_wdata[7:0];
            end
         endcase
      end
   end

   typedef struct {
      logic              port;   // 0 = A, 1 = B
      logic              we;
      logic [1:0]        size;
      logic              sgn;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [31:0]       exp_rdata;
      logic              exp_err;
      int                exp_lat;
      int                exp_cs;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic port, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err);
      vec_t v;
      v.port      = port;
      v.we        = we;
      v.size      = size;
      v.sgn       = sgn;
      v.addr      = addr;
      v.wdata     = wdata;
      v.exp_rdata = exp_rdata;
      v.exp_err   = exp_err;
      v.exp_lat   = exp_err ? 1 : 2;
      v.exp_cs    = exp_err ? 0 : 1;
      return v;
   endfunction

   task automatic idle_inputs();
      a_req = 0; a_we = 0; a_size = 0; a_signed = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_size = 0; b_signed = 0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Drive one request, wait (bounded) for its ack and compare everything about it.
   task automatic run_vec(input vec_t v, input int idx);
      int n, cs_cnt;
      logic got, er, other;
      logic [31:0] rd;
      @(posedge clk); #1;
      if (!v.port) begin
         a_we = v.we; a_size = v.size; a_signed = v.sgn; a_addr = v.addr; a_wdata = v.wdata; a_req = 1;
      end else begin
         b_we = v.we; b_size = v.size; b_signed = v.sgn; b_addr = v.addr; b_wdata = v.wdata; b_req = 1;
      end
      n = 0; cs_cnt = 0; got = 0; er = 0; other = 0; rd = '0;
      while (!got && n < 10) begin
         @(negedge clk);
         n++;
         if (dm_cs) cs_cnt++;
         if (!v.port) begin got = a_ack; rd = a_rdata; er = a_err; other = other | b_ack; end
         else         begin got = b_ack; rd = b_rdata; er = b_err; other = other | a_ack; end
      end
      check($sformatf("v%0d ack seen", idx), {31'd0, got}, 32'd1);
      check($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
      check($sformatf("v%0d err", idx), {31'd0, er}, {31'd0, v.exp_err});
      check($sformatf("v%0d latency", idx), 32'(n - 1), 32'(v.exp_lat));
      check($sformatf("v%0d dm_cs cycles", idx), 32'(cs_cnt), 32'(v.exp_cs));
      check($sformatf("v%0d other ack", idx), {31'd0, other}, 32'd0);
      @(posedge clk); #1;
      a_req = 0; b_req = 0;
   endtask

   initial begin
      int ngr, cyc;
      int gseq [4];
      logic [31:0] rds [4];
      logic seen;

      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      idle_inputs();
      rst_n = 1'b0;
      #12;
      check("reset ctrl outputs", {24'd0, busy, a_ack, b_ack, a_err, b_err, dm_cs, dm_r, dm_w}, 32'd0);
      check("reset a_rdata", a_rdata, 32'd0);
      check("reset dm_addr", {21'd0, dm_addr}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("idle busy", {31'd0, busy}, 32'd0);

      //               port we size sgn addr     wdata         exp_rdata     err
      tbl.push_back(mk(0, 1, 2'd2, 0, 11'h010, 32'h11223344, 32'h00000000, 0));
      tbl.push_back(mk(0, 0, 2'd2, 0, 11'h010, 32'h0,        32'h11223344, 0));
      tbl.push_back(mk(0, 1, 2'd0, 0, 11'h014, 32'h00000080, 32'h00000000, 0));
      tbl.push_back(mk(0, 0, 2'd0, 1, 11'h014, 32'h0,        32'hFFFFFF80, 0));
      tbl.push_back(mk(0, 0, 2'd0, 0, 11'h014, 32'h0,        32'h00000080, 0));
      tbl.push_back(mk(0, 0, 2'd0, 1, 11'h010, 32'h0,        32'h00000011, 0));
      tbl.push_back(mk(1, 1, 2'd1, 0, 11'h020, 32'h0000BEEF, 32'h00000000, 0));
      tbl.push_back(mk(1, 0, 2'd1, 1, 11'h020, 32'h0,        32'hFFFFBEEF, 0));
      tbl.push_back(mk(1, 0, 2'd1, 0, 11'h020, 32'h0,        32'h0000BEEF, 0));
      tbl.push_back(mk(0, 0, 2'd2, 0, 11'h020, 32'h0,        32'hBEEF0000, 0));
      tbl.push_back(mk(0, 0, 2'd2, 0, 11'h7FE, 32'h0,        32'h00000000, 1));
      tbl.push_back(mk(1, 0, 2'd1, 0, 11'h7FF, 32'h0,        32'h00000000, 1));
      tbl.push_back(mk(0, 1, 2'd3, 0, 11'h000, 32'h12345678, 32'h00000000, 1));
      tbl.push_back(mk(1, 1, 2'd0, 0, 11'h7FF, 32'h000000A5, 32'h00000000, 0));
      tbl.push_back(mk(0, 0, 2'd0, 0, 11'h7FF, 32'h0,        32'h000000A5, 0));
      tbl.push_back(mk(1, 0, 2'd1, 0, 11'h7FE, 32'h0,        32'h000000A5, 0));
      tbl.push_back(mk(0, 1, 2'd2, 0, 11'h000, 32'hCAFEF00D, 32'h00000000, 0));
      tbl.push_back(mk(0, 1, 2'd0, 0, 11'h004, 32'h0000005A, 32'h00000000, 0));
`ifdef DMEM_ALIGN_CHECK_EN
      tbl.push_back(mk(0, 0, 2'd2, 0, 11'h001, 32'h0,        32'h00000000, 1));
      tbl.push_back(mk(1, 0, 2'd1, 0, 11'h011, 32'h0,        32'h00000000, 1));
`else
      tbl.push_back(mk(0, 0, 2'd2, 0, 11'h001, 32'h0,        32'hFEF00D5A, 0));
      tbl.push_back(mk(1, 0, 2'd1, 0, 11'h011, 32'h0,        32'h00002233, 0));
`endif
      tbl.push_back(mk(1, 0, 2'd2, 1, 11'h000, 32'h0,        32'hCAFEF00D, 0));

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

      // Simultaneous requests held for four grants.
      do_reset();
      @(posedge clk); #1;
      a_we = 0; a_size = 2'd2; a_addr = 11'h010;
      b_we = 0; b_size = 2'd2; b_addr = 11'h020;
      a_req = 1; b_req = 1;
      ngr = 0; cyc = 0;
      for (int i = 0; i < 4; i++) begin gseq[i] = -1; rds[i] = '0; end
      while (ngr < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (a_ack && b_ack) check("arb double ack", 32'd1, 32'd0);
         if (a_ack)      begin gseq[ngr] = 0; rds[ngr] = a_rdata; ngr++; end
         else if (b_ack) begin gseq[ngr] = 1; rds[ngr] = b_rdata; ngr++; end
      end
      check("arb grant count", 32'(ngr), 32'd4);
      check("arb 4th ack cycle", 32'(cyc), 32'd12);
      for (int i = 0; i < 4; i++) begin
         int eg;
         eg = FAIR ? (i % 2) : 0;
         check($sformatf("arb grant %0d port", i), 32'(gseq[i]), 32'(eg));
         check($sformatf("arb grant %0d rdata", i), rds[i], (eg == 0) ? 32'h11223344 : 32'hBEEF0000);
      end
      @(posedge clk); #1;
      a_req = 0; b_req = 0;

      // Reset pulled during the ACCESS cycle of a store.
      do_reset();
      @(posedge clk); #1;
      a_we = 1; a_size = 2'd2; a_addr = 11'h040; a_wdata = 32'hDEADBEEF; a_req = 1;
      @(posedge clk); #1;
      check("mid-rst dm_w before", {31'd0, dm_w}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid-rst dm_w dropped", {31'd0, dm_w}, 32'd0);
      check("mid-rst dm_cs dropped", {31'd0, dm_cs}, 32'd0);
      check("mid-rst busy", {31'd0, busy}, 32'd0);
      a_req = 0;
      seen = 0;
      repeat (2) begin @(negedge clk); seen = seen | a_ack | b_ack; end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) begin @(negedge clk); seen = seen | a_ack | b_ack | dm_cs; end
      check("mid-rst no ack", {31'd0, seen}, 32'd0);
      check("mid-rst mem unchanged", {mem[64], mem[65], mem[66], mem[67]}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
